// File: rtl/radix3_in_commutator.sv
// Radix-3 input commutator: buffers the first two thirds of each serial frame
// and emits (x[k], x[k+M], x[k+2M]) triplets while the final third streams in.
module radix3_in_commutator #(
  parameter int DW = 32,
  parameter int M  = 3,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_img,
  output logic          out_valid,
  output logic [DW-1:0] a_re,
  output logic [DW-1:0] a_img,
  output logic [DW-1:0] b_re,
  output logic [DW-1:0] b_img,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] c_img,
  output logic          frame_done,
  output logic          sof_err
);

  typedef enum logic [1:0] {FILL0, FILL1, PASS} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic          out_valid_q, out_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          sof_err_q, sof_err_d;
  logic [DW-1:0] a_re_q, a_re_d, a_img_q, a_img_d;
  logic [DW-1:0] b_re_q, b_re_d, b_img_q, b_img_d;
  logic [DW-1:0] c_re_q, c_re_d, c_img_q, c_img_d;

  logic [DW-1:0] bank0_re  [2**AW];
  logic [DW-1:0] bank0_img [2**AW];
  logic [DW-1:0] bank1_re  [2**AW];
  logic [DW-1:0] bank1_img [2**AW];

  logic          bank0_we, bank1_we;
  logic [AW-1:0] bank0_addr;
  logic          last;

  assign last = (k_q == AW'(M - 1));

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    a_re_d       = a_re_q;
    a_img_d      = a_img_q;
    b_re_d       = b_re_q;
    b_img_d      = b_img_q;
    c_re_d       = c_re_q;
    c_img_d      = c_img_q;
    bank0_we     = 1'b0;
    bank1_we     = 1'b0;
    bank0_addr   = k_q;
    if (in_valid) begin
      if (in_sof && !(state_q == FILL0 && k_q == '0)) begin
        // Resync: the sof sample becomes bank0[0]; with M=1 that already completes FILL0.
        sof_err_d  = 1'b1;
        bank0_we   = 1'b1;
        bank0_addr = '0;
        if (M == 1) begin
          state_d = FILL1;
          k_d     = '0;
        end else begin
          state_d = FILL0;
          k_d     = AW'(1);
        end
      end else begin
        case (state_q)
          FILL0: begin
            bank0_we = 1'b1;
            k_d      = last ? '0 : k_q + AW'(1);
            if (last) state_d = FILL1;
          end
          FILL1: begin
            bank1_we = 1'b1;
            k_d      = last ? '0 : k_q + AW'(1);
            if (last) state_d = PASS;
          end
          PASS: begin
            out_valid_d  = 1'b1;
            frame_done_d = last;
            a_re_d       = bank0_re[k_q];
            a_img_d      = bank0_img[k_q];
            b_re_d       = bank1_re[k_q];
            b_img_d      = bank1_img[k_q];
            c_re_d       = in_re;
            c_img_d      = in_img;
            k_d          = last ? '0 : k_q + AW'(1);
            if (last) state_d = FILL0;
          end
          default: begin
            state_d = FILL0;
            k_d     = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL0;
      k_q          <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      a_re_q       <= '0;
      a_img_q      <= '0;
      b_re_q       <= '0;
      b_img_q      <= '0;
      c_re_q       <= '0;
      c_img_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
      a_re_q       <= a_re_d;
      a_img_q      <= a_img_d;
      b_re_q       <= b_re_d;
      b_img_q      <= b_img_d;
      c_re_q       <= c_re_d;
      c_img_q      <= c_img_d;
    end
  end

  // Bank storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (bank0_we) begin
      bank0_re[bank0_addr]  <= in_re;
      bank0_img[bank0_addr] <= in_img;
    end
    if (bank1_we) begin
      bank1_re[k_q]  <= in_re;
      bank1_img[k_q] <= in_img;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign a_re       = a_re_q;
  assign a_img      = a_img_q;
  assign b_re       = b_re_q;
  assign b_img      = b_img_q;
  assign c_re       = c_re_q;
  assign c_img      = c_img_q;

endmodule

// File: doc/radix3_in_commutator.md
Name: radix3_in_commutator

Overview:
- Front-end reorder block feeding the radix-3 butterfly stage.
- Takes a serial complex sample stream, one sample per accepted cycle. Frames are N = 3*M samples long.
- Emits parallel triplets (x[k], x[k+M], x[k+2M]) for k = 0..M-1 on the a/b/c lanes the butterfly consumes.
- Buffers the first two thirds of each frame in two banks, then streams triplets while the final third arrives.

Parameters:
- DW, 32, width of each real/imaginary word.
- M, 3, samples per frame segment; frame length N = 3*M; M >= 1.
- AW, 2, bank address width; must satisfy 2^AW >= M.

Ports:
- clk  in  1  clock; all registers on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_re  in  DW  input sample, real part.
- in_img  in  DW  input sample, imaginary part.
- out_valid  out  1  triplet valid this cycle.
- a_re, a_img  out  DW each  x[k].
- b_re, b_img  out  DW each  x[k+M].
- c_re, c_img  out  DW each  x[k+2M].
- frame_done  out  1  one-cycle pulse alongside the last triplet (k = M-1).
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset: rst high asynchronously forces state FILL0, k = 0, and drives all outputs to 0 (out_valid, frame_done, sof_err, and all data lanes).
  - Bank contents are not reset; they are don't-care.
- State machine: FILL0 -> FILL1 -> PASS -> FILL0, with segment counter k in 0..M-1.
  - Only cycles with in_valid = 1 advance k or state. in_valid = 0 holds everything, and out_valid = 0 on the next cycle.
- FILL0: bank0[k] <= in. When k = M-1, set k <= 0 and go to FILL1.
- FILL1: bank1[k] <= in. When k = M-1, set k <= 0 and go to PASS.
- PASS: register the triplet a = bank0[k], b = bank1[k], c = in.
  - out_valid = 1 on the cycle after acceptance, so latency is 1 cycle from the c-sample.
  - When k = M-1, also set frame_done = 1 with that triplet, then k <= 0 and go to FILL0.
- Output register: data lanes hold their last value when out_valid = 0. out_valid and frame_done are single-cycle pulses per accepted PASS sample.
- Back-to-back frames: a sample accepted in the cycle after the last PASS sample is index 0 of the next frame. No bubble is required.
- in_sof handling (only when in_valid = 1):
  - in_sof = 1 with state FILL0 and k = 0: normal frame start.
  - in_sof = 1 at any other state or k: abort the partial frame. The sample is stored as bank0[0], k <= 1, state FILL0, sof_err pulses 1 on the next cycle, and no triplet is emitted for this sample.
  - in_sof = 0 at a frame start is accepted as index 0 (free-running framing).
- M = 1: FILL0 and FILL1 each take one sample; every third accepted sample emits a triplet with frame_done = 1.
- No output backpressure: the butterfly pipeline always accepts, so there is no in_ready.
- Arithmetic: none. Data passes bit-exact and is not interpreted (IEEE-754 or fixed-point are both fine).
- Reset mid-frame: the partial frame is discarded, and outputs go to 0 immediately (asynchronous), not on the next edge.

Test Plan:
- Reset check (M=3): hold rst high -> out_valid = 0, frame_done = 0, sof_err = 0, all data lanes = 0.
- Basic frame (M=3): continuous frame re = 1..9, img = 101..109, in_sof on the first sample.
  - Triplets (1,4,7)/(101,104,107), (2,5,8), (3,6,9) appear on the 3 cycles after samples 7, 8, 9 are accepted.
  - frame_done = 1 only with (3,6,9).
- Gaps: same frame with in_valid = 0 after every sample -> identical triplets; out_valid pulses only after accepted samples 7, 8, 9.
- Back-to-back: two frames (1..9, then 11..19) with no gap.
  - Second frame's triplets are (11,14,17), (12,15,18), (13,16,19).
  - 6 frame_done pulses total? No: exactly 2 frame_done pulses.
- Mid-frame resync: send 1..5, then in_sof with 21 followed by 22..29.
  - sof_err pulses once; no triplet is emitted from the aborted frame.
  - Triplets (21,24,27), (22,25,28), (23,26,29) follow.
- Async reset mid-PASS: assert rst between samples 7 and 8 -> outputs 0 immediately; after release, a fresh frame 31..39 yields (31,34,37), (32,35,38), (33,36,39).
